bp_fe_queue_dual_fifo: RTL

Two-wide in-order FIFO between the dual-issue front end and the back end. Accepts up to two FE queue entries per cycle from `bp_fe_top` (slots 1 and 2, slot 1 older). Presents the two oldest entries to `bp_be_top`, which may consume 0, 1 or 2 per cycle. A flush input drops all buffered entries when the BE redirects the FE.

---
 rtl/bp_fe_queue_dual_fifo.sv | 112 +++++++++++
 1 files changed

// File: rtl/bp_fe_queue_dual_fifo.sv
// Two-wide in-order FIFO between the dual-issue front end and the back end.
// Up to two entries enter per cycle (slot 1 older than slot 2). The two oldest
// entries are presented to the BE, which consumes 0, 1 or 2 per cycle.
// A flush (clr_i) drops every buffered entry at the next edge.
//
// Ports:
//   clk_i           clock, all state on posedge
//   reset_i         synchronous active-high reset
//   clr_i           flush: empties the FIFO at the next edge
//   enq_data1_i/v1  older incoming entry and its valid
//   enq_data2_i/v2  younger incoming entry and its valid (only with v1)
//   enq_ready_o     room for two entries this cycle
//   deq_data1_o/v1  oldest buffered entry and its valid
//   deq_data2_o/v2  second-oldest buffered entry and its valid
//   deq_yumi_cnt_i  number of entries consumed this cycle (0..2)
module bp_fe_queue_dual_fifo #(
  parameter int unsigned els_p         = 8,
  // Stand-in for fe_queue_width_lp; integrators override with the real width.
  parameter int unsigned entry_width_p = 64
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     clr_i,

  input  logic [entry_width_p-1:0] enq_data1_i,
  input  logic                     enq_v1_i,
  input  logic [entry_width_p-1:0] enq_data2_i,
  input  logic                     enq_v2_i,
  output logic                     enq_ready_o,

  output logic [entry_width_p-1:0] deq_data1_o,
  output logic                     deq_v1_o,
  output logic [entry_width_p-1:0] deq_data2_o,
  output logic                     deq_v2_o,
  input  logic [1:0]               deq_yumi_cnt_i
);

  localparam int unsigned ptr_w_lp = $clog2(els_p);
  localparam int unsigned cnt_w_lp = $clog2(els_p + 1);

  logic [entry_width_p-1:0] mem_r [els_p];

  logic [ptr_w_lp-1:0] rptr_r, rptr_nxt, rptr_p1;
  logic [ptr_w_lp-1:0] wptr_r, wptr_nxt, wptr_p1;
  logic [cnt_w_lp-1:0] count_r, count_nxt;

  logic       enq_fire;
  logic [1:0] enq_n;

  // Ready looks only at the registered count so there is no path from yumi.
  assign enq_ready_o = !reset_i && (count_r <= cnt_w_lp'(els_p - 2));
  assign enq_fire    = enq_ready_o && enq_v1_i;
  assign enq_n       = enq_fire ? (enq_v2_i ? 2'd2 : 2'd1) : 2'd0;

  // Power-of-two depth: pointer arithmetic wraps naturally.
  assign rptr_p1 = rptr_r + ptr_w_lp'(1);
  assign wptr_p1 = wptr_r + ptr_w_lp'(1);

  assign deq_v1_o    = (count_r >= cnt_w_lp'(1));
  assign deq_v2_o    = (count_r >= cnt_w_lp'(2));
  assign deq_data1_o = mem_r[rptr_r];
  assign deq_data2_o = mem_r[rptr_p1];

  // Next-state for pointers and occupancy; flush wins over enq/deq.
  always_comb begin
    rptr_nxt  = rptr_r;
    wptr_nxt  = wptr_r;
    count_nxt = count_r;
    if (clr_i) begin
      rptr_nxt  = wptr_r;
      count_nxt = '0;
    end else begin
      rptr_nxt  = rptr_r + ptr_w_lp'(deq_yumi_cnt_i);
      wptr_nxt  = wptr_r + ptr_w_lp'(enq_n);
      count_nxt = count_r + cnt_w_lp'(enq_n) - cnt_w_lp'(deq_yumi_cnt_i);
    end
  end

  // Pointer / occupancy registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_r  <= '0;
      wptr_r  <= '0;
      count_r <= '0;
    end else begin
      rptr_r  <= rptr_nxt;
      wptr_r  <= wptr_nxt;
      count_r <= count_nxt;
    end
  end

  // Storage is never cleared; a flushed enqueue is simply not written.
  always_ff @(posedge clk_i) begin
    if (enq_fire && !clr_i) begin
      mem_r[wptr_r] <= enq_data1_i;
      if (enq_v2_i) begin
        mem_r[wptr_p1] <= enq_data2_i;
      end
    end
  end

`ifndef SYNTHESIS
  // Protocol checks on the FE and BE sides.
  a_v2_needs_v1: assert property (@(posedge clk_i) disable iff (reset_i)
    !(enq_v2_i && !enq_v1_i));
  a_yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i)
    (deq_yumi_cnt_i != 2'd3) && (cnt_w_lp'(deq_yumi_cnt_i) <= count_r));
  a_v_known: assert property (@(posedge clk_i) disable iff (reset_i)
    !$isunknown({enq_v1_i, enq_v2_i}));
`endif

endmodule
